cpu_control_unit: RTL and testbench

- Microsequencer for the 8-bit bus CPU.
- Owns the instruction register, the step counter and the carry/zero flags.
- Drives every bus enable and write enable, including the ALU and its A/B registers, so only one source drives the shared bus per cycle.
- Runs fetch/decode/execute as a step-counted state machine, compensating for the ALU's one-cycle registered result.

---
 rtl/cpu_control_unit.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
// ----------------
// Step-counted microsequencer for the 8-bit bus CPU. It holds the instruction
// register, the T0..T5 step counter, the carry/zero flags and the halt latch,
// and decodes them into every bus enable and write enable. This guarantees
// that only one source drives the shared bus in any cycle.
//
// Ports
//   clk               system clock, rising edge
//   rst               synchronous active-low reset
//   bus_in            shared bus; loads IR at T1, feeds zero detect at ALU T5
//   carry_in          ALU carry out, latched at ADD/SUB T5
//   bus_out           {0, IR operand} while ir_enable, otherwise all ones
//   pc_enable/pc_inc/pc_load                  program counter controls
//   mar_write_enable                          MAR load
//   ram_enable/ram_write_enable               RAM drive / write
//   ir_enable                                 IR operand drives bus
//   alu_enable/sub_enable                     ALU drive / subtract mode
//   rega_enable/rega_write_enable             A register drive / load
//   regb_write_enable                         B register load
//   out_write_enable                          output register load
//   carry_flag/zero_flag/halted               latched status
module cpu_control_unit #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             pc_enable,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mar_write_enable,
    output logic             ram_enable,
    output logic             ram_write_enable,
    output logic             ir_enable,
    output logic             alu_enable,
    output logic             rega_enable,
    output logic             rega_write_enable,
    output logic             regb_write_enable,
    output logic             sub_enable,
    output logic             out_write_enable,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             halted
);
    localparam int OPW = WIDTH - ADDR_WIDTH;

    localparam logic [OPW-1:0] OP_LDA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(6);
    localparam logic [OPW-1:0] OP_JC  = OPW'(7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
    localparam logic [OPW-1:0] OP_OUT = OPW'(14);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} step_t;

    typedef struct packed {
        logic pc_enable;
        logic pc_inc;
        logic pc_load;
        logic mar_we;
        logic ram_enable;
        logic ram_we;
        logic ir_enable;
        logic alu_enable;
        logic rega_enable;
        logic rega_we;
        logic regb_we;
        logic sub_enable;
        logic out_we;
    } ctrl_t;

    step_t            step, step_nxt, end_step;
    logic [WIDTH-1:0] ir;
    logic             c_q, z_q, halted_q;
    ctrl_t            ctl;
    logic             ir_write, flag_we, halt_set;

    wire [OPW-1:0] opcode = ir[WIDTH-1:ADDR_WIDTH];

    // Final step of the current instruction; ADD/SUB spend T4 waiting on the
    // ALU's registered result before it is put on the bus at T5.
    always_comb begin
        end_step = T2;
        case (opcode)
            OP_ADD, OP_SUB: end_step = T5;
            OP_LDA, OP_STA: end_step = T3;
            default:        end_step = T2;
        endcase
    end

    always_comb begin
        ctl      = '0;
        ir_write = 1'b0;
        flag_we  = 1'b0;
        halt_set = 1'b0;
        // Reset and halt both silence the whole control word.
        if (rst && !halted_q) begin
            case (step)
                T0: begin
                    ctl.pc_enable = 1'b1;
                    ctl.mar_we    = 1'b1;
                end
                T1: begin
                    ctl.ram_enable = 1'b1;
                    ctl.pc_inc     = 1'b1;
                    ir_write       = 1'b1;
                end
                default: begin
                    case (opcode)
                        OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                            if (step == T2) begin
                                ctl.ir_enable = 1'b1;
                                ctl.mar_we    = 1'b1;
                            end
                            if (step == T3) begin
                                if (opcode == OP_STA) begin
                                    ctl.rega_enable = 1'b1;
                                    ctl.ram_we      = 1'b1;
                                end else begin
                                    ctl.ram_enable = 1'b1;
                                    ctl.rega_we    = (opcode == OP_LDA);
                                    ctl.regb_we    = (opcode != OP_LDA);
                                end
                            end
                            if (step == T5 && (opcode == OP_ADD || opcode == OP_SUB)) begin
                                ctl.alu_enable = 1'b1;
                                ctl.rega_we    = 1'b1;
                                flag_we        = 1'b1;
                            end
                            // Subtract mode held from B load through result write-back.
                            ctl.sub_enable = (opcode == OP_SUB) && (step >= T3) && (step <= T5);
                        end
                        OP_LDI: if (step == T2) begin
                            ctl.ir_enable = 1'b1;
                            ctl.rega_we   = 1'b1;
                        end
                        OP_JMP, OP_JC, OP_JZ: begin
                            if (step == T2 && (opcode == OP_JMP ||
                                               (opcode == OP_JC && c_q) ||
                                               (opcode == OP_JZ && z_q))) begin
                                ctl.ir_enable = 1'b1;
                                ctl.pc_load   = 1'b1;
                            end
                        end
                        OP_OUT: if (step == T2) begin
                            ctl.rega_enable = 1'b1;
                            ctl.out_we      = 1'b1;
                        end
                        OP_HLT: halt_set = (step == T2);
                        default: ;  // NOP and undefined opcodes
                    endcase
                end
            endcase
        end
    end

    // Any step at or past the instruction's end wraps to fetch, so an
    // unreachable code cannot wedge the counter.
    always_comb begin
        if (step >= T2 && step >= end_step) step_nxt = T0;
        else                                step_nxt = step_t'(step + 3'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            step     <= T0;
            ir       <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            step <= step_nxt;
            if (ir_write) ir <= bus_in;
            if (flag_we) begin
                c_q <= carry_in;
                z_q <= (bus_in == '0);
            end
            if (halt_set) halted_q <= 1'b1;
        end
    end

    assign bus_out           = ctl.ir_enable ? {{OPW{1'b0}}, ir[ADDR_WIDTH-1:0]} : '1;
    assign pc_enable         = ctl.pc_enable;
    assign pc_inc            = ctl.pc_inc;
    assign pc_load           = ctl.pc_load;
    assign mar_write_enable  = ctl.mar_we;
    assign ram_enable        = ctl.ram_enable;
    assign ram_write_enable  = ctl.ram_we;
    assign ir_enable         = ctl.ir_enable;
    assign alu_enable        = ctl.alu_enable;
    assign rega_enable       = ctl.rega_enable;
    assign rega_write_enable = ctl.rega_we;
    assign regb_write_enable = ctl.regb_we;
    assign sub_enable        = ctl.sub_enable;
    assign out_write_enable  = ctl.out_we;
    assign carry_flag        = c_q;
    assign zero_flag         = z_q;
    assign halted            = halted_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit. The driver issues one cycle of inputs
// per clock and queues the hand-computed expected outputs; the monitor pops
// one entry each falling edge and compares.
module tb_cpu_control_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_in;
    logic       carry_in;
    logic [7:0] bus_out;
    logic pc_enable, pc_inc, pc_load, mar_write_enable, ram_enable, ram_write_enable;
    logic ir_enable, alu_enable, rega_enable, rega_write_enable, regb_write_enable;
    logic sub_enable, out_write_enable, carry_flag, zero_flag, halted;

    always #5 clk = ~clk;

    cpu_control_unit #(.WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .carry_in(carry_in), .bus_out(bus_out),
        .pc_enable(pc_enable), .pc_inc(pc_inc), .pc_load(pc_load),
        .mar_write_enable(mar_write_enable), .ram_enable(ram_enable),
        .ram_write_enable(ram_write_enable), .ir_enable(ir_enable),
        .alu_enable(alu_enable), .rega_enable(rega_enable),
        .rega_write_enable(rega_write_enable), .regb_write_enable(regb_write_enable),
        .sub_enable(sub_enable), .out_write_enable(out_write_enable),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .halted(halted)
    );

    localparam logic [12:0] PCE  = 13'h1000, PCI  = 13'h0800, PCL  = 13'h0400,
                            MARW = 13'h0200, RAME = 13'h0100, RAMW = 13'h0080,
                            IRE  = 13'h0040, ALUE = 13'h0020, RAE  = 13'h0010,
                            RAW  = 13'h0008, RBW  = 13'h0004, SUB  = 13'h0002,
                            OUTW = 13'h0001;

    typedef struct {
        logic [12:0] ctl;
        logic [7:0]  bo;
        logic        c, z, h;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic fc = 1'b0, fz = 1'b0;   // expected flags, updated by hand after ALU ops

    wire [12:0] act_ctl = {pc_enable, pc_inc, pc_load, mar_write_enable, ram_enable,
                           ram_write_enable, ir_enable, alu_enable, rega_enable,
                           rega_write_enable, regb_write_enable, sub_enable,
                           out_write_enable};

    task automatic cyc(input logic r, input logic [7:0] bi, input logic ci,
                       input logic [12:0] ctl, input logic [7:0] bo,
                       input logic c, input logic z, input logic h, input string nm);
        exp_t e;
        @(posedge clk); #1;
        rst = r; bus_in = bi; carry_in = ci;
        e.ctl = ctl; e.bo = bo; e.c = c; e.z = z; e.h = h; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic ex(input logic [12:0] ctl, input logic [7:0] bo, input string nm);
        cyc(1'b1, 8'h00, 1'b0, ctl, bo, fc, fz, 1'b0, nm);
    endtask

    task automatic fetch(input logic [7:0] instr, input string nm);
        cyc(1'b1, 8'h00, 1'b0, PCE | MARW, 8'hFF, fc, fz, 1'b0, {nm, "_t0"});
        cyc(1'b1, instr, 1'b0, RAME | PCI, 8'hFF, fc, fz, 1'b0, {nm, "_t1"});
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int   drivers;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (act_ctl !== e.ctl || bus_out !== e.bo || carry_flag !== e.c ||
                    zero_flag !== e.z || halted !== e.h) begin
                    errors++;
                    $display("FAIL %s: got ctl=%h bus=%h c=%b z=%b h=%b, want ctl=%h bus=%h c=%b z=%b h=%b",
                             e.nm, act_ctl, bus_out, carry_flag, zero_flag, halted,
                             e.ctl, e.bo, e.c, e.z, e.h);
                end
                drivers = int'(pc_enable) + int'(ram_enable) + int'(ir_enable) +
                          int'(alu_enable) + int'(rega_enable);
                checks++;
                if (drivers > 1 || (rega_write_enable && regb_write_enable)) begin
                    errors++;
                    $display("FAIL %s_invariant: got drivers=%0d a_we=%b b_we=%b, want drivers<=1 and not both we",
                             e.nm, drivers, rega_write_enable, regb_write_enable);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; bus_in = 8'h00; carry_in = 1'b0;
        // Reset held two cycles
        cyc(1'b0, 8'h00, 1'b0, 13'h0, 8'hFF, 1'b0, 1'b0, 1'b0, "reset0");
        cyc(1'b0, 8'h00, 1'b0, 13'h0, 8'hFF, 1'b0, 1'b0, 1'b0, "reset1");
        // LDI 5
        fetch(8'h55, "ldi");
        ex(IRE | RAW, 8'h05, "ldi_t2");
        // ADD 3, carry 1 and zero result -> C=1 Z=1
        fetch(8'h23, "add");
        ex(IRE | MARW, 8'h03, "add_t2");
        ex(RAME | RBW, 8'hFF, "add_t3");
        ex(13'h0, 8'hFF, "add_t4");
        cyc(1'b1, 8'h00, 1'b1, ALUE | RAW, 8'hFF, fc, fz, 1'b0, "add_t5");
        fc = 1'b1; fz = 1'b1;
        // SUB A, carry 0 and result 07 -> C=0 Z=0
        fetch(8'h3A, "sub");
        ex(IRE | MARW, 8'h0A, "sub_t2");
        ex(RAME | RBW | SUB, 8'hFF, "sub_t3");
        ex(SUB, 8'hFF, "sub_t4");
        cyc(1'b1, 8'h07, 1'b0, ALUE | RAW | SUB, 8'hFF, fc, fz, 1'b0, "sub_t5");
        fc = 1'b0; fz = 1'b0;
        // ADD 3 again, carry 0 and zero result -> C=0 Z=1
        fetch(8'h23, "add2");
        ex(IRE | MARW, 8'h03, "add2_t2");
        ex(RAME | RBW, 8'hFF, "add2_t3");
        ex(13'h0, 8'hFF, "add2_t4");
        cyc(1'b1, 8'h00, 1'b0, ALUE | RAW, 8'hFF, fc, fz, 1'b0, "add2_t5");
        fz = 1'b1;
        // JC 9 with C=0: not taken
        fetch(8'h79, "jc");
        ex(13'h0, 8'hFF, "jc_t2");
        // JZ 9 with Z=1: taken
        fetch(8'h89, "jz");
        ex(IRE | PCL, 8'h09, "jz_t2");
        // JMP 6
        fetch(8'h66, "jmp");
        ex(IRE | PCL, 8'h06, "jmp_t2");
        // STA 2
        fetch(8'h42, "sta");
        ex(IRE | MARW, 8'h02, "sta_t2");
        ex(RAE | RAMW, 8'hFF, "sta_t3");
        // OUT
        fetch(8'hE0, "out");
        ex(RAE | OUTW, 8'hFF, "out_t2");
        // NOP and an undefined opcode behave identically
        fetch(8'h00, "nop");
        ex(13'h0, 8'hFF, "nop_t2");
        fetch(8'hB7, "undef");
        ex(13'h0, 8'hFF, "undef_t2");
        // LDA C aborted by reset at T3; flags (C=0 Z=1) cleared by that edge
        fetch(8'h1C, "lda");
        ex(IRE | MARW, 8'h0C, "lda_t2");
        cyc(1'b0, 8'h00, 1'b0, 13'h0, 8'hFF, fc, fz, 1'b0, "lda_rst");
        fc = 1'b0; fz = 1'b0;
        // HLT: fetch restarts at T0 right after release
        fetch(8'hF0, "hlt");
        ex(13'h0, 8'hFF, "hlt_t2");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 8'h00, 1'b0, 13'h0, 8'hFF, 1'b0, 1'b0, 1'b1, "halted");
        // Only reset leaves halt
        cyc(1'b0, 8'h00, 1'b0, 13'h0, 8'hFF, 1'b0, 1'b0, 1'b1, "hlt_rst");
        fetch(8'h55, "post_rst");
        // Drain scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
